// File: rtl/ex_mem_pipe_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_stage
//
// EX->MEM pipeline register for the RISC-V core. It holds one instruction
// between the ALU/forwarding stage and the data-memory stage. It uses a
// valid/ready handshake on both sides. A synchronous flush turns the held
// instruction into a bubble. A saturating counter records output stall cycles.
//
// Build option:
//   EX_MEM_SKID_EN  When defined, a one-entry skid buffer sits behind the
//                   output register. in_ready then comes straight from a
//                   flop and has no combinational path from out_ready. When
//                   undefined, in_ready is combinational and no skid storage
//                   exists.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   in_valid / in_ready   EX-side handshake
//   in_rs1, in_rs2, in_rd register addresses            (REG_AW bits)
//   in_alu_result         ALU result / effective address (XLEN bits)
//   in_store_data         store data                     (XLEN bits)
//   in_mem_size           funct3 access size / signedness (3 bits)
//   in_reg_write          writeback enable
//   in_out_sel            writeback mux select           (SEL_W bits)
//   in_mem_write          store
//   in_mem_read           load
//   flush                 kills the held and the incoming instruction
//   out_valid / out_ready MEM-side handshake
//   out_*                 registered copies of the in_* fields
//   cnt_clr               synchronous clear of stall_cnt
//   stall_cnt             saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module ex_mem_pipe_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [2:0]        in_mem_size,
    input  logic              in_reg_write,
    input  logic [SEL_W-1:0]  in_out_sel,
    input  logic              in_mem_write,
    input  logic              in_mem_read,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_store_data,
    output logic [2:0]        out_mem_size,
    output logic              out_reg_write,
    output logic [SEL_W-1:0]  out_out_sel,
    output logic              out_mem_write,
    output logic              out_mem_read,
    input  logic              cnt_clr,
    output logic [SCNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [2:0]        mem_size;
        logic              reg_write;
        logic [SEL_W-1:0]  out_sel;
        logic              mem_write;
        logic              mem_read;
    } payload_t;

    payload_t          w_in;
    payload_t          r_out;
    logic              r_valid;
    logic [SCNT_W-1:0] r_stall_cnt;
    logic              w_out_free;
    logic              w_stall;

    // The incoming payload carries its control bits gated by in_valid, so a
    // bubble can never carry a write or read enable into the MEM stage.
    always_comb begin
        // NOTE: assign every field a default first so that no path through
        //       this block leaves a bit unassigned, which would infer a latch.
        w_in            = '0;
        w_in.rs1        = in_rs1;
        w_in.rs2        = in_rs2;
        w_in.rd         = in_rd;
        w_in.alu_result = in_alu_result;
        w_in.store_data = in_store_data;
        w_in.mem_size   = in_mem_size;
        w_in.out_sel    = in_out_sel;
        w_in.reg_write  = in_reg_write & in_valid;
        w_in.mem_write  = in_mem_write & in_valid;
        w_in.mem_read   = in_mem_read  & in_valid;
    end

    // The output register can take a new value when it is empty or when its
    // content leaves this cycle.
    assign w_out_free = !r_valid || out_ready;
    assign w_stall    = r_valid && !out_ready;

`ifdef EX_MEM_SKID_EN
    payload_t r_skid;
    logic     r_in_ready;   // 1 = skid entry empty

    assign in_ready = r_in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            // Drop both the held and the buffered instruction. The data
            // fields keep their old values; only the enables are cleared.
            r_valid         <= 1'b0;
            r_out.reg_write <= 1'b0;
            r_out.mem_write <= 1'b0;
            r_out.mem_read  <= 1'b0;
            r_in_ready      <= 1'b1;
        end else if (w_out_free) begin
            if (!r_in_ready) begin
                // The older instruction waits in the skid entry. It goes
                // first. in_ready was low, so no input was accepted this
                // cycle.
                r_valid    <= 1'b1;
                r_out      <= r_skid;
                r_in_ready <= 1'b1;
            end else begin
                r_valid <= in_valid;
                r_out   <= w_in;
            end
        end else if (in_valid && r_in_ready) begin
            // The output is held but the input was accepted: park it.
            r_skid     <= w_in;
            r_in_ready <= 1'b0;
        end
    end
`else
    logic w_load;

    assign in_ready = w_out_free || flush;
    assign w_load   = w_out_free && !flush;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the payload register is reset as well as the valid bit,
        //       because every output must read 0 while reset is asserted.
        if (!reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (flush) begin
            r_valid         <= 1'b0;
            r_out.reg_write <= 1'b0;
            r_out.mem_write <= 1'b0;
            r_out.mem_read  <= 1'b0;
        end else if (w_load) begin
            r_valid <= in_valid;
            r_out   <= w_in;
        end
    end
`endif

    // Saturating stall counter. Flush does not affect it. A clear wins over
    // a coincident stall cycle.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: flops are updated only with non-blocking assignments, so
        //       every always_ff samples pre-edge values regardless of order.
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
        end
    end

    assign out_valid      = r_valid;
    assign out_rs1        = r_out.rs1;
    assign out_rs2        = r_out.rs2;
    assign out_rd         = r_out.rd;
    assign out_alu_result = r_out.alu_result;
    assign out_store_data = r_out.store_data;
    assign out_mem_size   = r_out.mem_size;
    assign out_reg_write  = r_out.reg_write;
    assign out_out_sel    = r_out.out_sel;
    assign out_mem_write  = r_out.mem_write;
    assign out_mem_read   = r_out.mem_read;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_pipe_stage
//
// Self-checking bench for ex_mem_pipe_stage. The DUT is built with
// SCNT_W = 4 so that counter saturation is reachable quickly.
//
// A negedge scoreboard records every accepted instruction. It compares each
// instruction that leaves the stage against the oldest recorded one. A flush
// or reset empties the scoreboard.
//
// The scenario tasks below also check outputs directly, one posedge + 1
// after each edge.
// -----------------------------------------------------------------------------
module tb_ex_mem_pipe_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int SEL_W  = 2;
    localparam int SCNT_W = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   sd;
        logic [2:0]        size;
        logic              rw;
        logic [SEL_W-1:0]  sel;
        logic              mw;
        logic              mr;
    } item_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0]   in_alu_result, in_store_data;
    logic [2:0]        in_mem_size;
    logic              in_reg_write;
    logic [SEL_W-1:0]  in_out_sel;
    logic              in_mem_write, in_mem_read;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0]   out_alu_result, out_store_data;
    logic [2:0]        out_mem_size;
    logic              out_reg_write;
    logic [SEL_W-1:0]  out_out_sel;
    logic              out_mem_write, out_mem_read;
    logic              cnt_clr;
    logic [SCNT_W-1:0] stall_cnt;

    item_t sb[$];
    item_t mon_exp, mon_obs;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_pops   = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(
        .XLEN(XLEN), .REG_AW(REG_AW), .SEL_W(SEL_W), .SCNT_W(SCNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_mem_size(in_mem_size), .in_reg_write(in_reg_write),
        .in_out_sel(in_out_sel), .in_mem_write(in_mem_write),
        .in_mem_read(in_mem_read), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_alu_result(out_alu_result),
        .out_store_data(out_store_data), .out_mem_size(out_mem_size),
        .out_reg_write(out_reg_write), .out_out_sel(out_out_sel),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic item_t make_item(input int rd_i);
        item_t it;
        int    k;
        it.rs1  = REG_AW'($urandom);
        it.rs2  = REG_AW'($urandom);
        it.rd   = REG_AW'(rd_i);
        it.alu  = $urandom;
        it.sd   = $urandom;
        it.size = 3'($urandom_range(0, 7));
        it.rw   = 1'($urandom_range(0, 1));
        it.sel  = SEL_W'($urandom_range(0, 3));
        k       = int'($urandom_range(0, 2));
        it.mw   = (k == 1);
        it.mr   = (k == 2);
        return it;
    endfunction

    task automatic drive(input item_t it, input logic v);
        in_valid      = v;
        in_rs1        = it.rs1;
        in_rs2        = it.rs2;
        in_rd         = it.rd;
        in_alu_result = it.alu;
        in_store_data = it.sd;
        in_mem_size   = it.size;
        in_reg_write  = it.rw;
        in_out_sel    = it.sel;
        in_mem_write  = it.mw;
        in_mem_read   = it.mr;
    endtask

    // ------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (!reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                n_pops++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra_transfer: got out_rd=%0d, expected no transfer", out_rd);
                end else begin
                    mon_exp = sb.pop_front();
                    mon_obs = '{rs1: out_rs1, rs2: out_rs2, rd: out_rd,
                                alu: out_alu_result, sd: out_store_data,
                                size: out_mem_size, rw: out_reg_write,
                                sel: out_out_sel, mw: out_mem_write,
                                mr: out_mem_read};
                    if (mon_obs !== mon_exp) begin
                        n_fail++;
                        $display("FAIL sb_payload: got %h expected %h", mon_obs, mon_exp);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                               alu: in_alu_result, sd: in_store_data,
                               size: in_mem_size, rw: in_reg_write,
                               sel: in_out_sel, mw: in_mem_write,
                               mr: in_mem_read});
        end
    end

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        item_t it;
        tick();
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(make_item(9), 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL pre_reset_load: got valid=%b rd=%0d expected valid=1 rd=9", out_valid, out_rd);
        end
        out_ready = 1'b0;
        drive(make_item(11), 1'b1);
        tick();
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_rd !== '0 || out_alu_result !== '0 ||
            out_reg_write !== 1'b0 || out_mem_write !== 1'b0 || out_mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b rd=%0d alu=%h expected all 0", out_valid, out_rd, out_alu_result);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        in_valid = 1'b0;
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        it        = make_item(5);
        it.alu    = 32'h0000_1234;
        drive(it, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_alu_result !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL first_load: got valid=%b rd=%0d alu=%h expected valid=1 rd=5 alu=00001234", out_valid, out_rd, out_alu_result);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(make_item(i), 1'b1);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_rd !== REG_AW'(i)) begin
                n_fail++;
                $display("FAIL b2b_rd: got valid=%b rd=%0d expected valid=1 rd=%0d", out_valid, out_rd, i);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        item_t it7;
        int    p0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        it7       = make_item(7);
        drive(it7, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL stall_load: got valid=%b rd=%0d expected valid=1 rd=7", out_valid, out_rd);
        end
        for (int k = 0; k < 3; k++) begin
            drive(make_item(20 + k), 1'b1);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_alu_result !== it7.alu) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b rd=%0d alu=%h expected valid=1 rd=7 alu=%h", out_valid, out_rd, out_alu_result, it7.alu);
            end
        end
        n_checks++;
        if (stall_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL stall_cnt3: got %0d expected 3", stall_cnt);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p0        = n_pops;
        tick();
        n_checks++;
        if (n_pops - p0 !== 1) begin
            n_fail++;
            $display("FAIL stall_release: got %0d transfers expected 1", n_pops - p0);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL stall_drain: got valid=%b pending=%0d expected valid=0 pending=0", out_valid, sb.size());
        end
        n_checks++;
        if (stall_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL stall_cnt_after: got %0d expected 3", stall_cnt);
        end
    endtask

    task automatic test_bubble();
        item_t it;
        out_ready = 1'b1;
        it        = make_item(3);
        it.rw     = 1'b1;
        it.mw     = 1'b1;
        it.mr     = 1'b0;
        drive(it, 1'b0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_ctrl: got valid=%b rw=%b mw=%b expected 0 0 0", out_valid, out_reg_write, out_mem_write);
        end
        n_checks++;
        if (out_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL bubble_data: got rd=%0d expected 3", out_rd);
        end
    endtask

    task automatic test_flush();
        item_t it;
        out_ready = 1'b0;
        it        = make_item(12);
        it.mw     = 1'b1;
        it.mr     = 1'b0;
        drive(it, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got valid=%b mw=%b expected 1 1", out_valid, out_mem_write);
        end
        drive(make_item(13), 1'b1);
        tick();
`ifdef EX_MEM_SKID_EN
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_skid_full: got in_ready=%b expected 0", in_ready);
        end
`endif
        drive(make_item(14), 1'b1);
        flush = 1'b1;
        #1;
`ifndef EX_MEM_SKID_EN
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready_during: got %b expected 1", in_ready);
        end
`endif
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_mem_write !== 1'b0 || out_rd !== 5'd12) begin
            n_fail++;
            $display("FAIL flush_result: got valid=%b mw=%b rd=%0d expected 0 0 12", out_valid, out_mem_write, out_rd);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready_after: got %b expected 1", in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_resurrect: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clear0: got %0d expected 0", stall_cnt);
        end
        out_ready = 1'b0;
        drive(make_item(8), 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (stall_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL sat_cnt5: got %0d expected 5", stall_cnt);
        end
        repeat (15) tick();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_cnt15: got %0d expected 15", stall_cnt);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clr_during_stall: got %0d expected 0", stall_cnt);
        end
        tick();
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_restart: got %0d expected 1", stall_cnt);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_release: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random_traffic();
        int p0;
        p0 = n_pops;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(make_item(i % 32), 1'($urandom_range(0, 1)));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (sb.size() !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: got pending=%0d valid=%b expected 0 0", sb.size(), out_valid);
        end
        n_checks++;
        if (n_pops - p0 < 50) begin
            n_fail++;
            $display("FAIL random_throughput: got %0d transfers expected at least 50", n_pops - p0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        test_reset();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_flush();
        test_saturation();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
